// File: rtl/stream_mem_responder.sv
// Memory-side responder: executes valid/ready requests on an internal register file
// and returns each response as a fixed-latency, non-backpressurable pulse.
module stream_mem_responder #(
    parameter int unsigned NumWords  = 16,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = $clog2(NumWords)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         stall_i,
    input  logic                         mem_req_valid_i,
    output logic                         mem_req_ready_o,
    input  logic                         mem_req_we_i,
    input  logic [AddrWidth-1:0]         mem_req_addr_i,
    input  logic [DataWidth-1:0]         mem_req_wdata_i,
    output logic                         mem_resp_valid_o,
    output logic [DataWidth-1:0]         mem_resp_rdata_o,
    output logic                         mem_resp_err_o,
    output logic [$clog2(Latency+1)-1:0] inflight_o
);

    localparam int unsigned CntWidth = $clog2(Latency + 1);
    localparam logic [AddrWidth:0] WordCount = NumWords[AddrWidth:0];

    // Handshake: a request transfers in any cycle where valid and ready are both high;
    // ready does not depend on valid, and a refused requester holds valid and payload.
    logic                 accept;
    logic                 addr_ok;
    logic [DataWidth-1:0] resp_data;

    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 stg_vld_q  [Latency];
    logic                 stg_vld_d  [Latency];
    logic [DataWidth-1:0] stg_data_q [Latency];
    logic [DataWidth-1:0] stg_data_d [Latency];
    logic                 stg_err_q  [Latency];
    logic                 stg_err_d  [Latency];

    logic [CntWidth-1:0]  inflight_q;
    logic [CntWidth-1:0]  inflight_d;

    assign mem_req_ready_o = !rst_i && !stall_i;
    assign accept          = mem_req_valid_i && mem_req_ready_o;
    assign addr_ok         = {1'b0, mem_req_addr_i} < WordCount;

    // Writes echo their own data; reads see only writes committed in earlier cycles.
    always_comb begin
        resp_data = '0;
        if (addr_ok) begin
            resp_data = mem_req_we_i ? mem_req_wdata_i : mem_q[mem_req_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept && mem_req_we_i && addr_ok) begin
            mem_q[mem_req_addr_i] <= mem_req_wdata_i;
        end
    end

    // Idle stages carry zero data so the outputs are clean whenever valid is low.
    always_comb begin
        stg_vld_d[0]  = accept;
        stg_data_d[0] = accept ? resp_data : '0;
        stg_err_d[0]  = accept && !addr_ok;
        for (int i = 1; i < Latency; i++) begin
            stg_vld_d[i]  = stg_vld_q[i-1];
            stg_data_d[i] = stg_data_q[i-1];
            stg_err_d[i]  = stg_err_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                stg_vld_q[i]  <= 1'b0;
                stg_data_q[i] <= '0;
                stg_err_q[i]  <= 1'b0;
            end
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            stg_err_q  <= stg_err_d;
        end
    end

    assign mem_resp_valid_o = stg_vld_q[Latency-1];
    assign mem_resp_rdata_o = stg_data_q[Latency-1];
    assign mem_resp_err_o   = stg_err_q[Latency-1];

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !mem_resp_valid_o) begin
            inflight_d = inflight_q + CntWidth'(1);
        end else if (!accept && mem_resp_valid_o) begin
            inflight_d = inflight_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight_o = inflight_q;

endmodule

// File: tb/tb_stream_mem_responder.sv
// Bench for stream_mem_responder: two instances (16 words/latency 1, 10 words/latency 3)
// share one request stream and are checked against a timestamped expected-response model.
module tb_stream_mem_responder;

    localparam int NW_A  = 16;
    localparam int LAT_A = 1;
    localparam int NW_B  = 10;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        stall = 1'b0;
    logic        valid = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  addr  = '0;
    logic [15:0] wdata = '0;

    logic        rdy_a, rv_a, err_a;
    logic [15:0] rd_a;
    logic [0:0]  inf_a;
    logic        rdy_b, rv_b, err_b;
    logic [15:0] rd_b;
    logic [1:0]  inf_b;

    stream_mem_responder #(.NumWords(NW_A), .DataWidth(16), .Latency(LAT_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .mem_req_valid_i(valid), .mem_req_ready_o(rdy_a), .mem_req_we_i(we),
        .mem_req_addr_i(addr), .mem_req_wdata_i(wdata),
        .mem_resp_valid_o(rv_a), .mem_resp_rdata_o(rd_a), .mem_resp_err_o(err_a),
        .inflight_o(inf_a)
    );

    stream_mem_responder #(.NumWords(NW_B), .DataWidth(16), .Latency(LAT_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .mem_req_valid_i(valid), .mem_req_ready_o(rdy_b), .mem_req_we_i(we),
        .mem_req_addr_i(addr), .mem_req_wdata_i(wdata),
        .mem_resp_valid_o(rv_b), .mem_resp_rdata_o(rd_b), .mem_resp_err_o(err_b),
        .inflight_o(inf_b)
    );

    typedef struct {
        int          due;
        logic [15:0] d;
        logic        e;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] mem_m [2][16];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic        rst_prev    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Compare one instance's outputs this cycle against the response due now, if any.
    task automatic check_dut(input int k, input string tag, input logic rdy, input logic v,
                             input logic [15:0] d, input logic e, input int infl);
        exp_t h;
        bit   have;
        int   pend;
        have = 1'b0;
        if (k == 0) begin
            if (q_a.size() > 0 && q_a[0].due == cyc) begin h = q_a.pop_front(); have = 1'b1; end
            pend = q_a.size();
        end else begin
            if (q_b.size() > 0 && q_b[0].due == cyc) begin h = q_b.pop_front(); have = 1'b1; end
            pend = q_b.size();
        end
        chk({tag, "_ready"}, 32'(rdy), 32'(!rst && !stall));
        if (rst && !rst_prev) begin
            // First reset cycle: outputs still show the pipeline from before the edge.
            if (have && v) begin
                chk({tag, "_rdata"}, 32'(d), 32'(h.d));
                chk({tag, "_err"}, 32'(e), 32'(h.e));
            end
        end else if (have) begin
            chk({tag, "_valid"}, 32'(v), 32'd1);
            chk({tag, "_rdata"}, 32'(d), 32'(h.d));
            chk({tag, "_err"}, 32'(e), 32'(h.e));
            chk({tag, "_inflight"}, 32'(infl), 32'(pend + 1));
        end else begin
            chk({tag, "_valid"}, 32'(v), 32'd0);
            chk({tag, "_rdata"}, 32'(d), 32'd0);
            chk({tag, "_err"}, 32'(e), 32'd0);
            chk({tag, "_inflight"}, 32'(infl), 32'(pend));
        end
    endtask

    task automatic model_step(input int k);
        int   nw;
        int   lat;
        exp_t x;
        nw  = (k == 0) ? NW_A : NW_B;
        lat = (k == 0) ? LAT_A : LAT_B;
        if (rst) begin
            if (k == 0) q_a.delete(); else q_b.delete();
            for (int i = 0; i < 16; i++) mem_m[k][i] = '0;
        end else if (valid && !stall) begin
            x.due = cyc + lat;
            x.e   = (int'(addr) >= nw);
            if (x.e) begin
                x.d = '0;
            end else if (we) begin
                x.d = wdata;
                mem_m[k][addr] = wdata;
            end else begin
                x.d = mem_m[k][addr];
            end
            if (k == 0) q_a.push_back(x); else q_b.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, "a", rdy_a, rv_a, rd_a, err_a, int'(inf_a));
        check_dut(1, "b", rdy_b, rv_b, rd_b, err_b, int'(inf_b));
        model_step(0);
        model_step(1);
        rst_prev = rst;
    end

    task automatic step(input logic v, input logic w, input logic [3:0] a,
                        input logic [15:0] d, input logic s);
        valid = v;
        we    = w;
        addr  = a;
        wdata = d;
        stall = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    initial begin
        logic        pend_hold;
        logic        v, w, s, r;
        logic [3:0]  a;
        logic [15:0] d;

        // Reset held with a pending write that must not be accepted.
        rst = 1'b1;
        repeat (4) step(1'b1, 1'b1, 4'd3, 16'hDEAD, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 4'd3, 16'h0, 1'b0);
        step(1'b1, 1'b0, 4'd9, 16'h0, 1'b0);
        idle(4);

        // Write then immediate readback.
        step(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 4'd3, 16'h0, 1'b0);
        idle(4);

        // Fill eight words, then eight back-to-back reads.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'(i), 16'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(7 - i), 16'h0, 1'b0);
        idle(5);

        // Out-of-range write and read, plus neighbours to confirm nothing changed.
        step(1'b1, 1'b1, 4'd12, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 4'd12, 16'h0, 1'b0);
        step(1'b1, 1'b0, 4'd2, 16'h0, 1'b0);
        step(1'b1, 1'b0, 4'd15, 16'h0, 1'b0);
        idle(4);

        // Stall for four cycles while an older read is still in flight.
        step(1'b1, 1'b0, 4'd3, 16'h0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 4'd4, 16'h0, 1'b1);
        step(1'b1, 1'b0, 4'd4, 16'h0, 1'b0);
        idle(5);

        // Reset one cycle after two accepted reads; their responses must vanish.
        step(1'b1, 1'b0, 4'd5, 16'h0, 1'b0);
        step(1'b1, 1'b0, 4'd6, 16'h0, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
        rst = 1'b0;
        idle(5);
        step(1'b1, 1'b0, 4'd3, 16'h0, 1'b0);
        idle(4);

        // Random soak; a refused request is held stable until it is accepted.
        pend_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 3) == 0);
            if (pend_hold) begin
                v = 1'b1; w = we; a = addr; d = wdata;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                w = 1'($urandom_range(0, 1));
                a = 4'($urandom_range(0, 15));
                d = 16'($urandom);
            end
            pend_hold = v && (s || r);
            rst = r;
            step(v, w, a, d, s);
        end
        rst = 1'b0;
        idle(8);

        chk("drain_a", 32'(q_a.size()), 32'd0);
        chk("drain_b", 32'(q_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
